// File: rtl/cpu_pkg.sv
// Shared widths, flag bit positions and sequencer state encoding for the CPU slice.
package cpu_pkg;

    localparam int PC_W   = 8;
    localparam int FLAG_W = 4;
    localparam int CNT_W  = 16;

    // Positions of the NZVC bits inside the flags register
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;
    logic         at_max_s;

    assign at_max_s = (count_r == {W{1'b1}});

    // Count enabled cycles, holding once the maximum is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (en && !at_max_s) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, NZVC flags and run/step/halt control feeding the jump ROM.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC          = 8'h00,
    parameter bit              HALT_ON_SELF_JUMP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    input  logic              jump,
    input  logic [PC_W-1:0]   jaddr,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic              flags_we,
    output logic [PC_W-1:0]   pc,
    output logic [FLAG_W-1:0] nzvc,
    output logic              running,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    seq_state_t        state_r;
    seq_state_t        state_next_s;
    logic [PC_W-1:0]   pc_r;
    logic [FLAG_W-1:0] nzvc_r;
    logic              running_r;
    logic              halted_r;
    logic              advance_s;
    logic              self_jump_s;
    logic [PC_W-1:0]   pc_next_s;

    // Decide whether an instruction retires this cycle and where the FSM goes next
    always_comb begin
        state_next_s = state_r;
        advance_s    = 1'b0;
        self_jump_s  = 1'b0;
        pc_next_s    = pc_r;

        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_next_s = ST_RUN;
                end else if (step) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_next_s = ST_HALT;
                end else begin
                    advance_s    = 1'b1;
                    state_next_s = run ? ST_RUN : ST_IDLE;
                end
            end
            ST_STEP: begin
                advance_s    = 1'b1;
                state_next_s = ST_IDLE;
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        if (advance_s) begin
            pc_next_s   = jump ? jaddr : (pc_r + 8'd1);
            self_jump_s = HALT_ON_SELF_JUMP && jump && (jaddr == pc_r);
        end else begin
            pc_next_s   = pc_r;
            self_jump_s = 1'b0;
        end

        // A jump onto itself is a deliberate stop: retire it, then halt
        if (self_jump_s) begin
            state_next_s = ST_HALT;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State, PC, flags and status registers; reset aborts any in-flight instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            nzvc_r    <= 4'b0000;
            running_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            running_r <= (state_next_s == ST_RUN) || (state_next_s == ST_STEP);
            halted_r  <= (state_next_s == ST_HALT);
            if (advance_s && flags_we) begin
                nzvc_r <= flags_in;
            end else begin
                nzvc_r <= nzvc_r;
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_retired (
        .clk   (clk),
        .rst   (reset),
        .en    (advance_s),
        .count (retired)
    );

    assign pc      = pc_r;
    assign nzvc    = nzvc_r;
    assign running = running_r;
    assign halted  = halted_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus hand sequences for halt and reset.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic        halt_req;
    logic        jump;
    logic [7:0]  jaddr;
    logic [3:0]  flags_in;
    logic        flags_we;
    logic [7:0]  pc;
    logic [3:0]  nzvc;
    logic        running;
    logic        halted;
    logic [15:0] retired;

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic        run;
        logic        step;
        logic        halt_req;
        logic        jump;
        logic [7:0]  jaddr;
        logic        flags_we;
        logic [3:0]  flags_in;
        logic [7:0]  exp_pc;
        logic [3:0]  exp_nzvc;
        logic        exp_running;
        logic        exp_halted;
        logic [15:0] exp_retired;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    pc_sequencer #(
        .RESET_PC          (8'h10),
        .HALT_ON_SELF_JUMP (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .halt_req (halt_req),
        .jump     (jump),
        .jaddr    (jaddr),
        .flags_in (flags_in),
        .flags_we (flags_we),
        .pc       (pc),
        .nzvc     (nzvc),
        .running  (running),
        .halted   (halted),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic h, input logic j,
                                input logic [7:0] ja, input logic fw, input logic [3:0] fi,
                                input logic [7:0] epc, input logic [3:0] enz, input logic erun,
                                input logic ehalt, input logic [15:0] eret);
        vec_t v;
        v.run = r; v.step = s; v.halt_req = h; v.jump = j; v.jaddr = ja;
        v.flags_we = fw; v.flags_in = fi; v.exp_pc = epc; v.exp_nzvc = enz;
        v.exp_running = erun; v.exp_halted = ehalt; v.exp_retired = eret;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] epc, input logic [3:0] enz,
                         input logic erun, input logic ehalt, input logic [15:0] eret);
        n_checks++;
        if (pc !== epc) begin
            n_fail++;
            $display("FAIL %s pc: got %h expected %h", name, pc, epc);
        end
        n_checks++;
        if (nzvc !== enz) begin
            n_fail++;
            $display("FAIL %s nzvc: got %b expected %b", name, nzvc, enz);
        end
        n_checks++;
        if (running !== erun) begin
            n_fail++;
            $display("FAIL %s running: got %b expected %b", name, running, erun);
        end
        n_checks++;
        if (halted !== ehalt) begin
            n_fail++;
            $display("FAIL %s halted: got %b expected %b", name, halted, ehalt);
        end
        n_checks++;
        if (retired !== eret) begin
            n_fail++;
            $display("FAIL %s retired: got %0d expected %0d", name, retired, eret);
        end
    endtask

    // Drive inputs at the falling edge, then sample just after the next rising edge
    task automatic drive_cycle(input logic r, input logic s, input logic h, input logic j,
                               input logic [7:0] ja, input logic fw, input logic [3:0] fi);
        @(negedge clk);
        run = r; step = s; halt_req = h; jump = j; jaddr = ja; flags_we = fw; flags_in = fi;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        run = 1'b0; step = 1'b0; halt_req = 1'b0; jump = 1'b0;
        jaddr = 8'h00; flags_we = 1'b0; flags_in = 4'b0000;
        reset = 1'b1;
        #1;
        check("reset", 8'h10, 4'b0000, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        run = 1'b0; step = 1'b0; halt_req = 1'b0; jump = 1'b0;
        jaddr = 8'h00; flags_we = 1'b0; flags_in = 4'b0000;

        //            run   step  halt  jump  jaddr  fwe   fin      pc     nzvc     run   hlt   ret
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h10, 4'h0,    1'b1, 1'b0, 16'd0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h11, 4'h0,    1'b1, 1'b0, 16'd1);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h12, 4'h0,    1'b1, 1'b0, 16'd2);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h13, 4'h0,    1'b1, 1'b0, 16'd3);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 4'h0,    8'hFF, 4'h0,    1'b1, 1'b0, 16'd4);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h00, 4'h0,    1'b1, 1'b0, 16'd5);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 4'h0,    8'h20, 4'h0,    1'b1, 1'b0, 16'd6);
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 4'b0100, 8'h40, 4'b0100, 1'b1, 1'b0, 16'd7);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'b1001, 8'h41, 4'b1001, 1'b1, 1'b0, 16'd8);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h42, 4'b1001, 1'b0, 1'b0, 16'd9);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 4'hF,    8'h42, 4'b1001, 1'b0, 1'b0, 16'd9);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h42, 4'b1001, 1'b1, 1'b0, 16'd9);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h43, 4'b1001, 1'b0, 1'b0, 16'd10);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h43, 4'b1001, 1'b1, 1'b0, 16'd10);
        vecs[14] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0,    8'h44, 4'b1001, 1'b0, 1'b0, 16'd11);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'h0,    8'h44, 4'b1001, 1'b0, 1'b0, 16'd11);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h44, 4'b1001, 1'b1, 1'b0, 16'd11);
        vecs[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h45, 4'b1001, 1'b1, 1'b0, 16'd12);
        vecs[18] = mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 4'h6,    8'h45, 4'b1001, 1'b0, 1'b1, 16'd12);
        vecs[19] = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0,    8'h45, 4'b1001, 1'b0, 1'b1, 16'd12);

        do_reset();

        for (int i = 0; i < NVEC; i++) begin
            drive_cycle(vecs[i].run, vecs[i].step, vecs[i].halt_req, vecs[i].jump,
                        vecs[i].jaddr, vecs[i].flags_we, vecs[i].flags_in);
            check($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_nzvc,
                  vecs[i].exp_running, vecs[i].exp_halted, vecs[i].exp_retired);
        end

        // Self-jump: the jump retires, PC stays put, and the sequencer halts
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
        check("sj_enter", 8'h10, 4'h0, 1'b1, 1'b0, 16'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 4'h0);
        check("sj_goto05", 8'h05, 4'h0, 1'b1, 1'b0, 16'd1);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 4'h3);
        check("sj_halt", 8'h05, 4'h3, 1'b0, 1'b1, 16'd2);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
            check($sformatf("sj_step%0d", k), 8'h05, 4'h3, 1'b0, 1'b1, 16'd2);
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
            check($sformatf("sj_run%0d", k), 8'h05, 4'h3, 1'b0, 1'b1, 16'd2);
        end

        // Reset mid-RUN aborts the in-flight instruction before any edge
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 4'hA);
        check("mr_at33", 8'h33, 4'hA, 1'b1, 1'b0, 16'd1);
        @(negedge clk);
        jump = 1'b1; jaddr = 8'h60; flags_we = 1'b1; flags_in = 4'h5;
        #2;
        reset = 1'b1;
        #1;
        check("mr_async", 8'h10, 4'h0, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #1;
        check("mr_held", 8'h10, 4'h0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        reset = 1'b0; run = 1'b0; jump = 1'b0; flags_we = 1'b0;
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
        check("mr_step_in", 8'h10, 4'h0, 1'b1, 1'b0, 16'd0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0);
        check("mr_step_out", 8'h11, 4'h0, 1'b0, 1'b0, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and flags-register stage feeding the bottom (jump) ROM. It holds the 8-bit PC and the 4-bit NZVC flags that form the bottom ROM's 12-bit address. Each cycle it chooses the next PC: either the incremented PC or the jump target returned by the bottom ROM. A small run/step/halt state machine gates execution, and a retired-instruction counter supports debug.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- HALT_ON_SELF_JUMP, 1, when 1 a taken jump whose target equals the current PC enters HALT
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; while high in IDLE, enter RUN
- step  in  1  one-cycle pulse; in IDLE, execute exactly one instruction
- halt_req  in  1  level; forces HALT from RUN at the next edge
- jump  in  1  current instruction is a jump; PC takes `jaddr`
- jaddr  in  8  next-PC value from the bottom ROM output
- flags_in  in  4  NZVC from the ALU
- flags_we  in  1  load `flags_in` into the flags register
- pc  out  8  current PC; drives bottom ROM address bits [7:0]
- nzvc  out  4  flags register; drives bottom ROM address bits [11:8]
- running  out  1  high in RUN or STEP
- halted  out  1  high in HALT
- retired  out  16  count of executed instructions, saturating

## Operation
- States: IDLE, RUN, STEP, HALT. The state is an enum.
- IDLE:
  - `run`=1 -> RUN.
  - Else `step`=1 -> STEP.
  - Else stay.
  - PC, flags and counter are frozen.
- RUN: an instruction executes every cycle (the "advance" condition).
  - `halt_req`=1 -> HALT. No advance in that cycle.
  - Else `run`=0 -> IDLE after the current advance.
- STEP: one advance, then -> IDLE unconditionally.
- HALT: everything frozen. Exits only by reset.
- On advance:
  - PC <= `jump` ? `jaddr` : PC+1 (8-bit, 8'hFF wraps to 8'h00).
  - If `flags_we`, nzvc <= `flags_in`.
  - `retired` += 1, saturating at 16'hFFFF.
- Self-jump halt: if `jump` && `jaddr`==PC && HALT_ON_SELF_JUMP, the advance completes (PC unchanged, counter increments) and the state -> HALT at the same edge.
- Jump resolution uses the registered `nzvc`, i.e. the flags before the edge. Flags written at the same edge affect only the next instruction.
- Without an advance, `flags_we` and `jump` are ignored.

## Timing
- Reset (asynchronous, immediate):
  - pc=RESET_PC, nzvc=4'b0000, retired=0, state=IDLE.
  - running=0, halted=0.
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.
- Advance latency: inputs sampled at edge N appear on `pc`/`nzvc` after edge N.
- Bottom ROM loop: the ROM is combinational, so `jaddr` must be valid within the same cycle from `pc`/`nzvc`.
- `step` held high for several cycles yields one step per IDLE visit, i.e. every second cycle. `step` is ignored in RUN and HALT.
- `run` and `step` both high in IDLE: `run` wins.
- `halt_req` in IDLE or STEP is ignored. It takes effect only from RUN.
- Reset asserted mid-RUN aborts the in-flight instruction. No partial PC or flags update is visible.

## Structure
- Shared package cpu_pkg:
  - PC_W=8, FLAG_W=4, CNT_W=16.
  - Flag bit indices N=3, Z=2, V=1, C=0.
  - State enum seq_state_t.
- One natural sub-module: sat_counter (parameterised width, enable, async reset), used for `retired`.
- PC/flags registers and the FSM live in pc_sequencer.

## Test plan
- Reset with RESET_PC=8'h10, then run=1 for 3 cycles, no jumps -> pc 8'h10 -> 11 -> 12 -> 13, retired=3, running=1.
- PC at 8'hFF, advance with jump=0 -> pc=8'h00, no halt.
- pc=8'h20, jump=1, jaddr=8'h40, flags_we=1, flags_in=4'b0100 in the same cycle -> pc=8'h40, nzvc=4'b0100. The jump decision used the prior nzvc.
- pc=8'h05, jump=1, jaddr=8'h05 -> retired increments, halted=1 next cycle. Subsequent run/step pulses leave pc=8'h05.
- In IDLE, step pulse -> exactly one advance (pc+1), running high for one cycle, then IDLE. halt_req in RUN -> HALT with no advance.
- Assert reset mid-RUN at pc=8'h33 with flags_we=1 -> pc=RESET_PC, nzvc=0, retired=0 immediately, before the next clock edge.
